ofdm_subcarrier_mapper: RTL and testbench

Assembles mapped QPSK symbols into complete OFDM frequency-domain frames for the IFFT. It sits directly downstream of the QPSK mapper and takes its signed 8-bit I/Q pair as one data subcarrier. Each frame gets a null DC bin, null guard bins and fixed pilot bins, and is held in a ping-pong buffer. Frames are streamed to the IFFT in natural bin order, with start-of-frame and end-of-frame markers and valid/ready backpressure.

---
 rtl/ofdm_pkg.sv | 29 ++
 rtl/ofdm_pingpong_buf.sv | 63 ++++++
 rtl/ofdm_subcarrier_mapper.sv | 207 ++++++++++++++++++++
 tb/tb_ofdm_subcarrier_mapper.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_pkg.sv
// Shared defaults, state encodings and bin classification for the OFDM subcarrier mapper.
// Build option: OFDM_PILOT_EN inserts pilot bins; when undefined those bins carry data.
package ofdm_pkg;

   localparam int unsigned DEF_N_FFT     = 64;
   localparam int unsigned DEF_HALF_USED = 26;
   localparam int unsigned DEF_DATA_W    = 8;
   localparam int          DEF_PILOT_AMP = 20;

   typedef enum logic [1:0] {BIN_NULL, BIN_PILOT, BIN_DATA} bin_class_e;

   typedef enum logic {StFill, StWaitBuf} wr_state_e;
   typedef enum logic {StIdle, StStream} rd_state_e;

   // Classify bin k: DC and guard bins are null, pilots sit on active bins with k mod 8 == 4.
   function automatic bin_class_e bin_class(input int unsigned k,
                                            input int unsigned n_fft     = DEF_N_FFT,
                                            input int unsigned half_used = DEF_HALF_USED);
      bin_class_e cls;
      logic       active;
      active = ((k >= 1) && (k <= half_used)) || ((k >= n_fft - half_used) && (k < n_fft));
      cls    = active ? BIN_DATA : BIN_NULL;
`ifdef OFDM_PILOT_EN
      if (active && ((k % 8) == 4)) cls = BIN_PILOT;
`endif
      return cls;
   endfunction

endpackage

// File: rtl/ofdm_pingpong_buf.sv
// Two frame buffers with per-buffer full flags, one write port and one registered read port.
module ofdm_pingpong_buf
   import ofdm_pkg::*;
#(
   parameter int unsigned N_FFT  = DEF_N_FFT,
   parameter int unsigned DATA_W = DEF_DATA_W,
   localparam int unsigned AW    = $clog2(N_FFT)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  wr_en_i,
   input  logic                  wr_buf_i,
   input  logic [AW-1:0]         wr_addr_i,
   input  logic [2*DATA_W-1:0]   wr_data_i,
   input  logic                  set_full_i,
   input  logic                  rd_en_i,
   input  logic                  rd_buf_i,
   input  logic [AW-1:0]         rd_addr_i,
   output logic [2*DATA_W-1:0]   rd_data_o,
   input  logic                  clr_full_i,
   input  logic                  clr_buf_i,
   output logic [1:0]            full_o
);

   logic [2*DATA_W-1:0] mem0 [N_FFT];
   logic [2*DATA_W-1:0] mem1 [N_FFT];
   logic [1:0]          full_d, full_q;
   logic [2*DATA_W-1:0] rd_data_d, rd_data_q;

   // Set and clear address different buffers, so both apply on the same edge.
   always_comb begin
      full_d = full_q;
      if (clr_full_i) full_d[clr_buf_i] = 1'b0;
      if (set_full_i) full_d[wr_buf_i] = 1'b1;
   end

   // Read data register holds its value while no read is requested.
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en_i) rd_data_d = rd_buf_i ? mem1[rd_addr_i] : mem0[rd_addr_i];
   end

   // Frame storage, no reset needed: a buffer is only read after being fully written.
   always_ff @(posedge clk_i) begin
      if (wr_en_i && !wr_buf_i) mem0[wr_addr_i] <= wr_data_i;
      if (wr_en_i &&  wr_buf_i) mem1[wr_addr_i] <= wr_data_i;
   end

   // Flags and read register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         full_q    <= '0;
         rd_data_q <= '0;
      end else begin
         full_q    <= full_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign full_o    = full_q;
   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ofdm_subcarrier_mapper.sv
// OFDM subcarrier mapper: builds frames of null, pilot and data bins from QPSK symbols and
// streams them in natural bin order with sof/eof markers and valid/ready on both sides.
// Build option: OFDM_PILOT_EN (see ofdm_pkg::bin_class).
module ofdm_subcarrier_mapper
   import ofdm_pkg::*;
#(
   parameter int unsigned N_FFT     = DEF_N_FFT,
   parameter int unsigned HALF_USED = DEF_HALF_USED,
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int          PILOT_AMP = DEF_PILOT_AMP
) (
   input  logic                     CLOCK_50,
   input  logic                     reset,
   input  logic signed [DATA_W-1:0] in_i,
   input  logic signed [DATA_W-1:0] in_q,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic signed [DATA_W-1:0] out_i,
   output logic signed [DATA_W-1:0] out_q,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_sof,
   output logic                     out_eof,
   output logic [15:0]              frame_count
);

   localparam int unsigned AW = $clog2(N_FFT);
   localparam logic [AW-1:0] LAST = AW'(N_FFT - 1);

   wr_state_e           wr_state_d, wr_state_q;
   logic [AW-1:0]       wk_d, wk_q;
   logic                wbuf_d, wbuf_q;
   rd_state_e           rd_state_d, rd_state_q;
   logic [AW-1:0]       rk_d, rk_q;
   logic                rbuf_d, rbuf_q;
   logic                valid_d, valid_q, sof_d, sof_q, eof_d, eof_q;
   logic [15:0]         fc_d, fc_q;

   logic                wr_en, wr_buf, set_full, rd_en, rd_buf, rd_clr, other_free, in_hs;
   logic [AW-1:0]       wr_addr, rd_addr;
   logic [2*DATA_W-1:0] wr_data, rd_data;
   logic [1:0]          full;
   bin_class_e          wr_class;

   assign wr_class   = bin_class(32'(wk_q), N_FFT, HALF_USED);
   assign in_ready   = !reset && (wr_state_q == StFill) && (wr_class == BIN_DATA);
   assign in_hs      = in_valid && in_ready;
   // The other buffer can take writes if empty or released by the reader on this edge.
   assign other_free = !full[~wbuf_q] || (rd_clr && (rbuf_q == ~wbuf_q));

   // Write side: walk bins of the write buffer, stall on data bins without input.
   always_comb begin
      wr_state_d = wr_state_q;
      wk_d       = wk_q;
      wbuf_d     = wbuf_q;
      wr_en      = 1'b0;
      wr_buf     = wbuf_q;
      wr_addr    = wk_q;
      wr_data    = '0;
      set_full   = 1'b0;
      unique case (wr_state_q)
         StFill: begin
            unique case (wr_class)
               BIN_NULL:  wr_en = 1'b1;
               BIN_PILOT: begin
                  wr_en   = 1'b1;
                  wr_data = {DATA_W'(PILOT_AMP), {DATA_W{1'b0}}};
               end
               BIN_DATA: begin
                  wr_en   = in_hs;
                  wr_data = {in_i, in_q};
               end
               default: wr_en = 1'b0;
            endcase
            if (wr_en) begin
               wk_d = wk_q + 1'b1;
               if (wk_q == LAST) begin
                  set_full = 1'b1;
                  wk_d     = '0;
                  if (other_free) wbuf_d = ~wbuf_q;
                  else            wr_state_d = StWaitBuf;
               end
            end
         end
         StWaitBuf: begin
            // Bin 0 is always null, so write it on the release edge to keep frames gapless.
            if (other_free) begin
               wr_en      = 1'b1;
               wr_buf     = ~wbuf_q;
               wr_addr    = '0;
               wbuf_d     = ~wbuf_q;
               wk_d       = AW'(1);
               wr_state_d = StFill;
            end
         end
         default: wr_state_d = StFill;
      endcase
   end

   // Read side: stream the full read buffer, chaining straight into the other if ready.
   always_comb begin
      rd_state_d = rd_state_q;
      rk_d       = rk_q;
      rbuf_d     = rbuf_q;
      valid_d    = valid_q;
      sof_d      = sof_q;
      eof_d      = eof_q;
      fc_d       = fc_q;
      rd_en      = 1'b0;
      rd_buf     = rbuf_q;
      rd_addr    = '0;
      rd_clr     = 1'b0;
      unique case (rd_state_q)
         StIdle: begin
            if (full[rbuf_q]) begin
               rd_en      = 1'b1;
               rk_d       = '0;
               valid_d    = 1'b1;
               sof_d      = 1'b1;
               eof_d      = 1'b0;
               rd_state_d = StStream;
            end
         end
         StStream: begin
            if (out_ready) begin
               if (rk_q == LAST) begin
                  rd_clr = 1'b1;
                  rbuf_d = ~rbuf_q;
                  fc_d   = fc_q + 16'd1;
                  rk_d   = '0;
                  sof_d  = full[~rbuf_q];
                  eof_d  = 1'b0;
                  if (full[~rbuf_q]) begin
                     rd_en  = 1'b1;
                     rd_buf = ~rbuf_q;
                  end else begin
                     valid_d    = 1'b0;
                     rd_state_d = StIdle;
                  end
               end else begin
                  rd_en   = 1'b1;
                  rd_addr = rk_q + 1'b1;
                  rk_d    = rk_q + 1'b1;
                  sof_d   = 1'b0;
                  eof_d   = (rk_q == LAST - 1'b1);
               end
            end
         end
         default: rd_state_d = StIdle;
      endcase
   end

   // State registers for both FSMs, pointers and the frame counter.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         wr_state_q <= StFill;
         wk_q       <= '0;
         wbuf_q     <= 1'b0;
         rd_state_q <= StIdle;
         rk_q       <= '0;
         rbuf_q     <= 1'b0;
         valid_q    <= 1'b0;
         sof_q      <= 1'b0;
         eof_q      <= 1'b0;
         fc_q       <= '0;
      end else begin
         wr_state_q <= wr_state_d;
         wk_q       <= wk_d;
         wbuf_q     <= wbuf_d;
         rd_state_q <= rd_state_d;
         rk_q       <= rk_d;
         rbuf_q     <= rbuf_d;
         valid_q    <= valid_d;
         sof_q      <= sof_d;
         eof_q      <= eof_d;
         fc_q       <= fc_d;
      end
   end

   ofdm_pingpong_buf #(
      .N_FFT  (N_FFT),
      .DATA_W (DATA_W)
   ) u_buf (
      .clk_i      (CLOCK_50),
      .rst_i      (reset),
      .wr_en_i    (wr_en),
      .wr_buf_i   (wr_buf),
      .wr_addr_i  (wr_addr),
      .wr_data_i  (wr_data),
      .set_full_i (set_full),
      .rd_en_i    (rd_en),
      .rd_buf_i   (rd_buf),
      .rd_addr_i  (rd_addr),
      .rd_data_o  (rd_data),
      .clr_full_i (rd_clr),
      .clr_buf_i  (rbuf_q),
      .full_o     (full)
   );

   assign out_i       = rd_data[2*DATA_W-1 -: DATA_W];
   assign out_q       = rd_data[DATA_W-1:0];
   assign out_valid   = valid_q;
   assign out_sof     = sof_q;
   assign out_eof     = eof_q;
   assign frame_count = fc_q;

endmodule

// File: tb/tb_ofdm_subcarrier_mapper.sv
// Bench for ofdm_subcarrier_mapper: directed vector table plus multi-cycle sequences.
// Expectations follow the OFDM_PILOT_EN setting of the build.
module tb_ofdm_subcarrier_mapper;

   localparam int NF = 64;
`ifdef OFDM_PILOT_EN
   localparam int DATA_BINS = 46;
`else
   localparam int DATA_BINS = 52;
`endif

   logic       CLOCK_50 = 1'b0;
   logic       reset;
   logic [7:0] in_i, in_q, out_i, out_q;
   logic       in_valid, in_ready, out_valid, out_ready, out_sof, out_eof;
   logic [15:0] frame_count;

   always #5 CLOCK_50 = ~CLOCK_50;

   ofdm_subcarrier_mapper dut (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .in_i        (in_i),
      .in_q        (in_q),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_i       (out_i),
      .out_q       (out_q),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_sof     (out_sof),
      .out_eof     (out_eof),
      .frame_count (frame_count)
   );

   typedef struct {
      logic [7:0] i;
      logic [7:0] q;
      logic       sof;
      logic       eof;
      int         cyc;
      int         fc;
   } obin_t;

   typedef struct {
      int bin;
      int word;
   } vec_t;

   obin_t obins[$];
   vec_t  vecs[12];
   int    n_cmp = 0, n_bad = 0, cyc = 0, c0 = 0, next_sym = 1, n_acc = 0;
   logic  rst_drv = 1'b1, src_en = 1'b0;

   function automatic int w(input int i, input int q, input int sof, input int eof);
      return ((i & 255) << 10) | ((q & 255) << 2) | ((sof & 1) << 1) | (eof & 1);
   endfunction

   function automatic int word(input obin_t o);
      return (int'(o.i) << 10) | (int'(o.q) << 2) | (int'(o.sof) << 1) | int'(o.eof);
   endfunction

   function automatic obin_t bin_at(input int idx);
      obin_t d;
      d.i = 0; d.q = 0; d.sof = 0; d.eof = 0; d.cyc = -100000; d.fc = -1;
      if (idx >= 0 && idx < obins.size()) d = obins[idx];
      return d;
   endfunction

   // Reference class: 0 null, 1 pilot, 2 data.
   function automatic int ref_cls(input int k);
      if (k == 0 || (k > 26 && k < 38)) return 0;
`ifdef OFDM_PILOT_EN
      if (k % 8 == 4) return 1;
`endif
      return 2;
   endfunction

   function automatic int exp_word(input int s0, input int k);
      int n = 0;
      int sof = (k == 0) ? 1 : 0;
      int eof = (k == NF - 1) ? 1 : 0;
      for (int j = 0; j < k; j++) if (ref_cls(j) == 2) n++;
      case (ref_cls(k))
         0:       return w(0, 0, sof, eof);
         1:       return w(20, 0, sof, eof);
         default: return w(s0 + n, s0 + n, sof, eof);
      endcase
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One clock: drive at negedge, sample 1 time unit later, log handshakes.
   task automatic cycle(input logic rdy);
      obin_t o;
      @(negedge CLOCK_50);
      reset     = rst_drv;
      out_ready = rdy;
      in_valid  = src_en;
      in_i      = 8'(next_sym);
      in_q      = 8'(next_sym);
      #1;
      if (in_valid && in_ready) begin
         next_sym++;
         n_acc++;
      end
      if (out_valid && out_ready) begin
         o.i = out_i; o.q = out_q; o.sof = out_sof; o.eof = out_eof;
         o.cyc = cyc; o.fc = int'(frame_count);
         obins.push_back(o);
      end
      cyc++;
   endtask

   task automatic check_frame(input string name, input int base, input int s0);
      int bad = 0;
      for (int k = 0; k < NF; k++)
         if (base + k >= obins.size() || word(obins[base + k]) != exp_word(s0, k)) bad++;
      check(name, bad, 0);
   endtask

   task automatic do_reset();
      rst_drv = 1'b1;
      repeat (3) cycle(1'b1);
      check("rst in_ready", int'(in_ready), 0);
      check("rst out_valid", int'(out_valid), 0);
      check("rst out_sof", int'(out_sof), 0);
      check("rst out_eof", int'(out_eof), 0);
      check("rst out_iq", int'({out_i, out_q}), 0);
      check("rst frame_count", int'(frame_count), 0);
      rst_drv  = 1'b0;
      next_sym = 1;
      n_acc    = 0;
      obins.delete();
      c0 = cyc;
   endtask

   initial begin
      int    first_v, gaps, s0;
      logic  tog;
      obin_t b;

      reset = 1'b1; in_valid = 1'b0; in_i = '0; in_q = '0; out_ready = 1'b0;

      vecs[0]  = '{0,  w(0, 0, 1, 0)};
      vecs[1]  = '{1,  w(1, 1, 0, 0)};
      vecs[2]  = '{2,  w(2, 2, 0, 0)};
      vecs[3]  = '{3,  w(3, 3, 0, 0)};
      vecs[6]  = '{27, w(0, 0, 0, 0)};
      vecs[7]  = '{37, w(0, 0, 0, 0)};
`ifdef OFDM_PILOT_EN
      vecs[4]  = '{4,  w(20, 0, 0, 0)};
      vecs[5]  = '{5,  w(4, 4, 0, 0)};
      vecs[8]  = '{26, w(23, 23, 0, 0)};
      vecs[9]  = '{38, w(24, 24, 0, 0)};
      vecs[10] = '{44, w(20, 0, 0, 0)};
      vecs[11] = '{63, w(46, 46, 0, 1)};
`else
      vecs[4]  = '{4,  w(4, 4, 0, 0)};
      vecs[5]  = '{5,  w(5, 5, 0, 0)};
      vecs[8]  = '{26, w(26, 26, 0, 0)};
      vecs[9]  = '{38, w(27, 27, 0, 0)};
      vecs[10] = '{44, w(33, 33, 0, 0)};
      vecs[11] = '{63, w(52, 52, 0, 1)};
`endif

      // Continuous input and output for three frames.
      do_reset();
      src_en  = 1'b1;
      first_v = -1;
      gaps    = 0;
      for (int t = 0; t < 500 && obins.size() < 3 * NF; t++) begin
         cycle(1'b1);
         if (first_v < 0) begin
            if (out_valid) first_v = cyc - 1;
         end else if (!out_valid) gaps++;
      end
      check("t1 bins output", obins.size(), 3 * NF);
      check("t1 first valid latency", first_v - c0, 65);
      for (int v = 0; v < 12; v++)
         check($sformatf("t1 vec bin %0d", vecs[v].bin), word(bin_at(vecs[v].bin)), vecs[v].word);
      check("t1 sof spacing 1-2", bin_at(NF).cyc - bin_at(0).cyc, NF);
      check("t1 sof spacing 2-3", bin_at(2 * NF).cyc - bin_at(NF).cyc, NF);
      check("t1 count in frame 2", bin_at(NF).fc, 1);
      check("t1 count in frame 3", bin_at(2 * NF).fc, 2);
      check("t1 valid gaps", gaps, 0);
      check("t1 frame 2 bin 1 symbol", int'(bin_at(NF + 1).i), (1 + DATA_BINS) & 255);
      check_frame("t1 frame 1", 0, 1);
      check_frame("t1 frame 2", NF, 1 + DATA_BINS);
      check_frame("t1 frame 3", 2 * NF, 1 + 2 * DATA_BINS);
      cycle(1'b1);
      check("t1 frame_count 3", int'(frame_count), 3);

      // Output stalled from reset: both buffers fill, then input stops.
      do_reset();
      src_en = 1'b1;
      repeat (300) cycle(1'b0);
      check("t2 symbols accepted", n_acc, 2 * DATA_BINS);
      check("t2 in_ready", int'(in_ready), 0);
      check("t2 out_valid", int'(out_valid), 1);
      check("t2 out_sof", int'(out_sof), 1);
      check("t2 out_eof", int'(out_eof), 0);
      check("t2 out_iq held bin 0", int'({out_i, out_q}), 0);
      check("t2 frame_count", int'(frame_count), 0);

      // out_ready alternating 1,0.
      do_reset();
      src_en = 1'b1;
      tog    = 1'b1;
      for (int t = 0; t < 800 && obins.size() < 2 * NF; t++) begin
         cycle(tog);
         tog = ~tog;
      end
      check("t3 bins output", obins.size(), 2 * NF);
      check("t3 frame period", bin_at(NF).cyc - bin_at(0).cyc, 2 * NF);
      check_frame("t3 frame 1", 0, 1);
      check_frame("t3 frame 2", NF, 1 + DATA_BINS);

      // Reset while writing bin 30 of the second frame.
      do_reset();
      src_en = 1'b1;
      repeat (94) cycle(1'b1);
      check("t4 valid before reset", int'(out_valid), 1);
      rst_drv = 1'b1;
      cycle(1'b1);
      cycle(1'b1);
      check("t4 out_valid after reset", int'(out_valid), 0);
      check("t4 frame_count after reset", int'(frame_count), 0);
      check("t4 in_ready in reset", int'(in_ready), 0);
      rst_drv = 1'b0;
      obins.delete();
      s0 = next_sym;
      for (int t = 0; t < 300 && obins.size() < NF; t++) cycle(1'b1);
      b = bin_at(1);
      check("t4 bin 1 first new symbol", int'(b.i), s0 & 255);
      check_frame("t4 frame after reset", 0, s0);
      cycle(1'b1);
      check("t4 frame_count", int'(frame_count), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
